dmem_seq_ctrl: RTL and testbench

//  Burst sequencer for one DMem data memory tile. Accepts one burst command (read or write,

---
 rtl/dmem_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_seq_ctrl.sv
// Burst sequencer for a DMem tile: accepts one read/write burst command and walks
// base + n*stride one word per beat, driving DMem address, enable and port-routing lines.
module dmem_seq_ctrl #(
    parameter int unsigned AddrDMEM = 8,
    parameter int unsigned LenWidth = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic                cmd_hor,
    input  logic [AddrDMEM-1:0] cmd_base,
    input  logic [LenWidth-1:0] cmd_len,
    input  logic [AddrDMEM-1:0] cmd_stride,
    input  logic                stall,
    output logic [AddrDMEM-1:0] r_addr,
    output logic [AddrDMEM-1:0] w_addr,
    output logic                we_ram,
    output logic [1:0]          sel_ram_i,
    output logic [1:0]          sel_ram_o,
    output logic                beat,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AddrDMEM-1:0] r_cur_addr;
    logic [AddrDMEM-1:0] r_stride;
    logic [LenWidth-1:0] r_remain;
    logic                r_wr;
    logic                r_hor;
    logic                w_accept;
    logic                w_step;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_step   = (r_state == S_XFER) && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next = (cmd_len == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (w_step && (r_remain == LenWidth'(1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_addr <= '0;
            r_stride   <= '0;
            r_remain   <= '0;
            r_wr       <= 1'b0;
            r_hor      <= 1'b0;
        end else if (w_accept) begin
            r_cur_addr <= cmd_base;
            r_stride   <= cmd_stride;
            r_remain   <= cmd_len;
            r_wr       <= cmd_wr;
            r_hor      <= cmd_hor;
        end else if (w_step) begin
            // address wraps naturally at the DMem width
            r_cur_addr <= r_cur_addr + r_stride;
            r_remain   <= r_remain - LenWidth'(1);
        end
    end

    // outputs decode from state so an async reset drops we_ram at once
    always_comb begin
        cmd_ready = 1'b0;
        r_addr    = '0;
        w_addr    = '0;
        we_ram    = 1'b0;
        sel_ram_i = 2'b00;
        sel_ram_o = 2'b00;
        beat      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready = 1'b1;
            S_XFER: begin
                busy = 1'b1;
                beat = !stall;
                if (r_wr) begin
                    w_addr    = r_cur_addr;
                    we_ram    = !stall;
                    sel_ram_i = {1'b1, r_hor};
                end else begin
                    r_addr    = r_cur_addr;
                    sel_ram_o = {1'b1, r_hor};
                end
            end
            S_DONE:  done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Bench for dmem_seq_ctrl: directed scenarios with literal expectations plus random
// commands, all cycles compared against a queue-based burst model.
module tb_dmem_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic       cmd_hor;
    logic [7:0] cmd_base;
    logic [8:0] cmd_len;
    logic [7:0] cmd_stride;
    logic       stall;
    logic [7:0] r_addr;
    logic [7:0] w_addr;
    logic       we_ram;
    logic [1:0] sel_ram_i;
    logic [1:0] sel_ram_o;
    logic       beat;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_err = 0;

    dmem_seq_ctrl #(
        .AddrDMEM(8),
        .LenWidth(9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_hor   (cmd_hor),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .cmd_stride(cmd_stride),
        .stall     (stall),
        .r_addr    (r_addr),
        .w_addr    (w_addr),
        .we_ram    (we_ram),
        .sel_ram_i (sel_ram_i),
        .sel_ram_o (sel_ram_o),
        .beat      (beat),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // address of the i-th word of a burst, modulo the 8-bit DMem space
    function automatic int model_addr(input int base, input int stride, input int i);
        return (base + i * stride) % 256;
    endfunction

    // burst model: outstanding addresses in a queue, plus a pending done pulse
    int  m_q[$];
    bit  m_active = 0;
    bit  m_done   = 0;
    bit  m_wr     = 0;
    bit  m_hor    = 0;
    int  e_ready, e_r, e_w, e_we, e_si, e_so, e_beat, e_busy, e_done;

    always @(negedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_active = 0;
            m_done   = 0;
        end
        e_ready = 0; e_r = 0; e_w = 0; e_we = 0; e_si = 0; e_so = 0;
        e_beat = 0; e_busy = 0; e_done = 0;
        if (m_done) begin
            e_done = 1;
        end else if (m_active) begin
            e_busy = 1;
            e_beat = stall ? 0 : 1;
            if (m_wr) begin
                e_w  = m_q[0];
                e_we = stall ? 0 : 1;
                e_si = m_hor ? 3 : 2;
            end else begin
                e_r  = m_q[0];
                e_so = m_hor ? 3 : 2;
            end
        end else begin
            e_ready = 1;
        end
        chk("cmd_ready", int'(cmd_ready), e_ready);
        chk("r_addr",    int'(r_addr),    e_r);
        chk("w_addr",    int'(w_addr),    e_w);
        chk("we_ram",    int'(we_ram),    e_we);
        chk("sel_ram_i", int'(sel_ram_i), e_si);
        chk("sel_ram_o", int'(sel_ram_o), e_so);
        chk("beat",      int'(beat),      e_beat);
        chk("busy",      int'(busy),      e_busy);
        chk("done",      int'(done),      e_done);
        if (rst) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                if (!stall) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (cmd_valid) begin
                m_wr  = cmd_wr;
                m_hor = cmd_hor;
                if (cmd_len == 0) begin
                    m_done = 1;
                end else begin
                    for (int i = 0; i < int'(cmd_len); i++)
                        m_q.push_back(model_addr(int'(cmd_base), int'(cmd_stride), i));
                    m_active = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input bit hor, input int base, input int len, input int stride);
        cmd_valid  = 1'b1;
        cmd_wr     = wr;
        cmd_hor    = hor;
        cmd_base   = 8'(base);
        cmd_len    = 9'(len);
        cmd_stride = 8'(stride);
        stall      = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        stall     = 1'b0;
        repeat (n) step();
    endtask

    int exp_rd[4];

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_hor = 1'b0;
        cmd_base = '0; cmd_len = '0; cmd_stride = '0; stall = 1'b0;

        chk("model_wrap",   model_addr(8'hFE, 1, 2), 8'h00);
        chk("model_stride", model_addr(0, 4, 2), 8);
        chk("model_big",    model_addr(8'h80, 8'hC0, 3), 8'hC0);

        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_we",    int'(we_ram), 0);
        step();
        rst = 1'b1;
        idle_cycles(2);

        // write vertical, base 0x10, len 4
        issue(1, 0, 8'h10, 4, 1);
        @(negedge clk); chk("wv_ready", int'(cmd_ready), 1);
        step(); cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wv_addr", int'(w_addr), 8'h10 + i);
            chk("wv_we", int'(we_ram), 1);
            chk("wv_sel", int'(sel_ram_i), 2);
            step();
        end
        @(negedge clk); chk("wv_done", int'(done), 1);
        idle_cycles(1);

        // read horizontal with address wrap
        exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
        issue(0, 1, 8'hFE, 4, 1);
        step(); cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rh_addr", int'(r_addr), exp_rd[i]);
            chk("rh_sel", int'(sel_ram_o), 3);
            chk("rh_we", int'(we_ram), 0);
            step();
        end
        @(negedge clk); chk("rh_done", int'(done), 1);
        idle_cycles(1);

        // stall on the second beat for two cycles
        issue(1, 0, 0, 3, 1);
        step(); cmd_valid = 1'b0;
        @(negedge clk); chk("st_a0", int'(w_addr), 0); chk("st_we0", int'(we_ram), 1);
        step(); stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("st_hold", int'(w_addr), 1);
            chk("st_we_low", int'(we_ram), 0);
            chk("st_nobeat", int'(beat), 0);
            step();
        end
        stall = 1'b0;
        @(negedge clk); chk("st_a1", int'(w_addr), 1); chk("st_we1", int'(we_ram), 1);
        step();
        @(negedge clk); chk("st_a2", int'(w_addr), 2);
        step();
        @(negedge clk); chk("st_done", int'(done), 1);
        idle_cycles(1);

        // zero-length command
        issue(1, 1, 8'h33, 0, 1);
        step(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("z_done", int'(done), 1); chk("z_beat", int'(beat), 0); chk("z_ready", int'(cmd_ready), 0);
        step();
        @(negedge clk); chk("z_ready_back", int'(cmd_ready), 1); chk("z_done_off", int'(done), 0);
        idle_cycles(1);

        // stride 4 read, second command held valid through the burst
        issue(0, 0, 0, 3, 4);
        step();
        issue(1, 1, 8'h20, 2, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("s4_addr", int'(r_addr), 4 * i);
            step();
        end
        @(negedge clk); chk("b2b_done", int'(done), 1); chk("b2b_noready", int'(cmd_ready), 0);
        step();
        @(negedge clk); chk("b2b_ready", int'(cmd_ready), 1);
        step(); cmd_valid = 1'b0;
        @(negedge clk); chk("b2b_waddr0", int'(w_addr), 8'h20); chk("b2b_sel", int'(sel_ram_i), 3);
        step();
        @(negedge clk); chk("b2b_waddr1", int'(w_addr), 8'h21);
        idle_cycles(3);

        // async reset in the middle of a write burst
        issue(1, 0, 8'h40, 8, 2);
        step(); cmd_valid = 1'b0;
        step();
        chk("ar_we_before", int'(we_ram), 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_we", int'(we_ram), 0);
        chk("ar_ready", int'(cmd_ready), 1);
        chk("ar_busy", int'(busy), 0);
        step();
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk); chk("ar_nodone", int'(done), 0);
            step();
        end

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                cmd_wr     = 1'($urandom_range(0, 1));
                cmd_hor    = 1'($urandom_range(0, 1));
                cmd_base   = 8'($urandom_range(0, 255));
                cmd_stride = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                cmd_len    = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 40))
                                                         : 9'($urandom_range(0, 6));
            end
            cmd_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end
        idle_cycles(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
